aes_enc_round_ctrl: RTL and testbench

Iterative AES-128 encryption controller. It accepts one plaintext/key pair over a valid/ready handshake and runs the ten FIPS-197 rounds at one round per clock. It reuses the team's combinational round primitives (`subbytes`, `shiftrows`, `mixcolumns`) and expands the round key on the fly. The ciphertext is presented on a valid/ready output port. It sits between the AXI register wrapper of `aes_ip` and the round datapath, and owns all sequencing, round counting and key scheduling.

---
 rtl/aes_enc_round_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, ciphertext valid 11 cycles after acceptance.
// Back-pressure: the result is held stable in DONE until out_ready; no new job is accepted until it drains.
module aes_enc_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;

  st_t          st, st_nxt;
  logic [127:0] state_r, key_r;
  logic [3:0]   round_r;
  logic         load, step, round_ok;
  logic [127:0] nk, t, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte index 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, sw;
    w3 = k[31:0];
    sw = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = k[127:96] ^ sw ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign nk        = expand(key_r, rcon(round_r));
  assign t         = shiftrows(subbytes(state_r));
  assign round_out = (round_r < 4'd10) ? (mixcolumns(t) ^ nk) : (t ^ nk);
  assign round_ok  = (round_r >= 4'd1) && (round_r <= 4'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load   = 1'b1;
          st_nxt = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (!round_ok) st_nxt = IDLE;
        else begin
          step = 1'b1;
          if (round_r == 4'd10) st_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= '0;
      key_r   <= '0;
      round_r <= '0;
    end else if (load) begin
      state_r <= in_data ^ in_key;
      key_r   <= in_key;
      round_r <= 4'd1;
    end else if (step) begin
      state_r <= round_out;
      key_r   <= nk;
      round_r <= round_r + 4'd1;
    end
  end

  assign out_data = state_r;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed and random bench for aes_enc_round_ctrl against a table-driven AES-128 reference.
module tb_aes_enc_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_tab [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_enc_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] cmul(input int coef, input logic [7:0] x);
    case (coef)
      1:       return x;
      2:       return xt(x);
      default: return xt(x) ^ x;
    endcase
  endfunction

  // Classic generator walk: p steps by *3, q steps by /3, so q = p^-1; S(p) = affine(q).
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] r;
    int           mrow [4];
    mrow = '{2, 3, 1, 1};
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
               sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = u[4*((c+q)%4)+q];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) a[q] = s[4*c+q];
          for (int q = 0; q < 4; q++) begin
            s[4*c+q] = 8'h00;
            for (int k = 0; k < 4; k++) s[4*c+q] = s[4*c+q] ^ cmul(mrow[(k-q+4)%4], a[k]);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = s[4*c+q] ^ w[4*rnd+c][31-8*q -: 8];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // Presents a job while idle; returns the ciphertext and the cycle count up to out_valid.
  task automatic run_job(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] ct, output int lat);
    in_key   = k;
    in_data  = p;
    in_valid = 1'b1;
    tick();
    lat      = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    ct = out_data;
  endtask

  initial begin
    logic [127:0] ct, hold, k, p;
    logic [127:0] expq [$];
    int           lat, seen, cyc, sent, got, acc_prev;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    build_sbox();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    // FIPS-197 App. B, downstream ready
    run_job(KEY_B, PT_B, ct, lat);
    check("appb_ct", ct, CT_B);
    check("appb_latency", lat, 11);
    check("appb_busy_done", busy, 1);
    check("appb_in_ready_done", in_ready, 0);
    tick();
    check("appb_drain_valid", out_valid, 0);
    check("appb_drain_ready", in_ready, 1);

    // App. C.1 with 20 cycles of back-pressure
    out_ready = 1'b0;
    run_job(KEY_C, PT_C, ct, lat);
    check("appc_ct", ct, CT_C);
    check("appc_latency", lat, 11);
    hold = out_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data_stable", out_data, hold);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // in_valid pulsed during round 5 must be ignored
    in_key   = KEY_B;
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    in_key   = KEY_C;
    in_data  = PT_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_in_ready", in_ready, 0);
    lat = 6;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_ct", out_data, CT_B);
    check("ign_latency", lat, 11);
    tick();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    check("ign_no_second_job", seen, 0);

    // Asynchronous reset at round 6
    in_key   = KEY_B;
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();
    run_job(KEY_C, PT_C, ct, lat);
    check("post_rst_ct", ct, CT_C);
    check("post_rst_latency", lat, 11);
    tick();

    // 50 random jobs back-to-back with in_valid and out_ready held high
    cyc      = 0;
    sent     = 0;
    got      = 0;
    acc_prev = -1;
    while (got < 50 && cyc < 2000) begin
      if (out_valid) begin
        if (expq.size() == 0) check("b2b_spurious_out", 1, 0);
        else check("b2b_ct", out_data, expq.pop_front());
        got++;
      end
      if (in_ready) begin
        if (sent < 50) begin
          k = {$urandom, $urandom, $urandom, $urandom};
          p = {$urandom, $urandom, $urandom, $urandom};
          in_key   = k;
          in_data  = p;
          in_valid = 1'b1;
          expq.push_back(aes_ref(k, p));
          if (acc_prev >= 0) check("b2b_interval", cyc - acc_prev, 12);
          acc_prev = cyc;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", got, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
